// File: rtl/uart_frame_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler that wraps 64-bit words from NUM_REQ sources into
// 11-byte UART frames: SYNC, HDR, 8 payload bytes LSB first, XOR checksum.
module uart_frame_scheduler #(
  parameter int unsigned NUM_REQ   = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*64-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [7:0]            byte_data,
  output logic                  byte_start,
  input  logic                  byte_busy,
  input  logic                  byte_done,
  output logic                  sched_busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;
  state_t state, state_next;

  logic [1:0]  rr_ptr;
  logic [1:0]  grant;
  logic [1:0]  grant_sel;
  logic [1:0]  rr_next;
  logic        grant_found;
  int unsigned cand;
  logic [63:0] word;
  logic [3:0]  idx;
  logic [2:0]  pidx;
  logic [7:0]  chk;
  logic [7:0]  hdr;
  logic [7:0]  cur_byte;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_sel   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && 1'(req_valid >> cand)) begin
        grant_found = 1'b1;
        grant_sel   = 2'(cand);
      end
    end
    rr_next = 2'((32'(grant_sel) + 32'd1) % NUM_REQ);
  end

  always_comb begin
    hdr  = {2'b01, grant, 4'd8};
    pidx = idx[2:0] - 3'd2;
    case (idx)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = hdr;
      4'd10:   cur_byte = chk;
      default: cur_byte = word[{pidx, 3'b000} +: 8];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    sched_busy = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (sched_en && grant_found) state_next = LOAD;
      LOAD: begin
        sched_busy = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        sched_busy = 1'b1;
        if (!byte_busy) state_next = WAIT;
      end
      WAIT: begin
        sched_busy = 1'b1;
        if (byte_done) state_next = (idx == 4'd10) ? DONE : SEND;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant       <= '0;
      word        <= '0;
      idx         <= '0;
      chk         <= '0;
      req_ready   <= '0;
      byte_data   <= '0;
      byte_start  <= 1'b0;
      frame_count <= '0;
    end else begin
      req_ready  <= '0;
      byte_start <= 1'b0;
      case (state)
        IDLE: if (sched_en && grant_found) begin
          grant     <= grant_sel;
          word      <= 64'(req_data >> {grant_sel, 6'b000000});
          req_ready <= NUM_REQ'(1) << grant_sel;
          rr_ptr    <= rr_next;
        end
        LOAD: begin
          idx <= '0;
          chk <= '0;
        end
        SEND: if (!byte_busy) begin
          byte_data  <= cur_byte;
          byte_start <= 1'b1;
        end
        WAIT: if (byte_done) begin
          // Checksum covers HDR and payload only; SYNC and CHK itself are skipped.
          if (idx != 4'd0 && idx != 4'd10) chk <= chk ^ byte_data;
          if (idx != 4'd10) idx <= idx + 4'd1;
        end
        DONE: frame_count <= frame_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
`timescale 1ns/1ps
// Directed bench for uart_frame_scheduler with a byte-level UART stand-in
// (busy for BYTE_CYC cycles, one-cycle done, one cleanup cycle).
module tb_uart_frame_scheduler;

  localparam int BYTE_CYC = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sched_en = 1'b0;
  logic [2:0]   req_valid = '0;
  logic [63:0]  word_in [3];
  logic [191:0] req_data;
  logic [2:0]   req_ready;
  logic [7:0]   byte_data;
  logic         byte_start;
  logic         byte_busy;
  logic         byte_done;
  logic         sched_busy;
  logic         frame_done;
  logic [15:0]  frame_count;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int cyc = 0;
  int ucnt = 0;
  logic [7:0] line_q [$];
  int         start_q [$];
  logic [2:0] rdy_q [$];

  assign req_data = {word_in[2], word_in[1], word_in[0]};

  uart_frame_scheduler #(.NUM_REQ(3), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .byte_data(byte_data), .byte_start(byte_start), .byte_busy(byte_busy),
    .byte_done(byte_done), .sched_busy(sched_busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // UART stand-in and event logger, both on the falling edge.
  initial begin
    byte_busy = 1'b0;
    byte_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        ucnt = 0;
        byte_busy = 1'b0;
        byte_done = 1'b0;
      end else begin
        if (req_ready != 3'b000) rdy_q.push_back(req_ready);
        if (frame_done) fd_cnt++;
        byte_done = 1'b0;
        if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 1) byte_done = 1'b1;
          if (ucnt == 0) byte_busy = 1'b0;
        end else if (byte_start) begin
          line_q.push_back(byte_data);
          start_q.push_back(cyc);
          byte_busy = 1'b1;
          ucnt = BYTE_CYC;
        end
      end
    end
  end

  task automatic clear_logs;
    line_q.delete();
    start_q.delete();
    rdy_q.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    sched_en = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1 clear_logs();
  endtask

  task automatic send_word(input logic [1:0] id, input logic [63:0] d, output bit ok);
    word_in[id] = d;
    req_valid[id] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_fd(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (fd_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    int seen;
    rst_n = 1'b0;
    word_in[0] = '0; word_in[1] = '0; word_in[2] = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
    checks++; if (byte_start !== 1'b0) begin failures++; $display("FAIL reset_byte_start: got %b expected 0", byte_start); end
    checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data: got %h expected 00", byte_data); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_sched_busy: got %b expected 0", sched_busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL reset_frame_count: got %h expected 0000", frame_count); end
    rst_n = 1'b1;
    // Valid with sched_en low must not be granted.
    req_valid = 3'b001;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (req_ready != 3'b000 || sched_busy) seen++;
    end
    req_valid = '0;
    checks++; if (seen !== 0) begin failures++; $display("FAIL hold_when_disabled: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_single;
    logic [7:0] exp [11];
    bit ok;
    int bad;
    exp = '{8'hA5, 8'h48, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h48};
    do_reset();
    sched_en = 1'b1;
    send_word(2'd0, 64'h0123_4567_89AB_CDEF, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_grant: got timeout expected req_ready[0]"); end
    checks++; if (sched_busy !== 1'b1) begin failures++; $display("FAIL single_busy_load: got %b expected 1", sched_busy); end
    @(negedge clk); #1;
    checks++; if (byte_start !== 1'b0) begin failures++; $display("FAIL single_latency_early: got %b expected 0", byte_start); end
    @(negedge clk); #1;
    checks++; if (byte_start !== 1'b1 || byte_data !== 8'hA5) begin failures++; $display("FAIL single_latency: got start=%b data=%h expected start=1 data=a5", byte_start, byte_data); end
    wait_fd(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_frame_timeout: got %0d frames expected 1", fd_cnt); end
    checks++; if (line_q.size() !== 11) begin failures++; $display("FAIL single_len: got %0d expected 11", line_q.size()); end
    for (int i = 0; i < 11 && i < line_q.size(); i++) begin
      checks++; if (line_q[i] !== exp[i]) begin failures++; $display("FAIL single_byte%0d: got %h expected %h", i, line_q[i], exp[i]); end
    end
    bad = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != BYTE_CYC + 1) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL single_byte_gap: got %0d bad gaps expected 0", bad); end
    checks++; if (rdy_q.size() !== 1 || rdy_q[0] !== 3'b001) begin failures++; $display("FAIL single_ready: got %0d pulses first %b expected 1 pulse 001", rdy_q.size(), rdy_q[0]); end
    checks++; if (fd_cnt !== 1) begin failures++; $display("FAIL single_frame_done: got %0d expected 1", fd_cnt); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL single_frame_count: got %h expected 0001", frame_count); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_rdy [4];
    logic [7:0] exp_hdr [4];
    logic [7:0] exp_chk [4];
    int n;
    bit ok;
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_hdr = '{8'h48, 8'h58, 8'h68, 8'h48};
    exp_chk = '{8'hC9, 8'h58, 8'h97, 8'hC9};
    do_reset();
    word_in[0] = 64'h8000_0000_0000_0001;
    word_in[1] = 64'h1111_1111_1111_1111;
    word_in[2] = 64'h0000_0000_0000_00FF;
    sched_en = 1'b1;
    req_valid = 3'b111;
    n = 0;
    for (int i = 0; i < 2000 && n < 4; i++) begin
      @(negedge clk); #1;
      if (req_ready != 3'b000) n++;
    end
    req_valid = '0;
    wait_fd(4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_frames: got %0d expected 4", fd_cnt); end
    checks++; if (rdy_q.size() !== 4 || line_q.size() !== 44) begin failures++; $display("FAIL rr_counts: got %0d pulses %0d bytes expected 4 pulses 44 bytes", rdy_q.size(), line_q.size()); end
    for (int f = 0; f < 4; f++) begin
      if (f < rdy_q.size()) begin
        checks++; if (rdy_q[f] !== exp_rdy[f]) begin failures++; $display("FAIL rr_grant%0d: got %b expected %b", f, rdy_q[f], exp_rdy[f]); end
      end
      if (11*f + 10 < line_q.size()) begin
        checks++; if (line_q[11*f+1] !== exp_hdr[f]) begin failures++; $display("FAIL rr_hdr%0d: got %h expected %h", f, line_q[11*f+1], exp_hdr[f]); end
        checks++; if (line_q[11*f+10] !== exp_chk[f]) begin failures++; $display("FAIL rr_chk%0d: got %h expected %h", f, line_q[11*f+10], exp_chk[f]); end
      end
    end
  endtask

  task automatic test_sched_en;
    bit ok;
    int extra;
    do_reset();
    sched_en = 1'b1;
    word_in[2] = 64'hFEDC_BA98_7654_3210;
    send_word(2'd1, 64'h1111_1111_1111_1111, ok);
    req_valid[2] = 1'b1;
    for (int i = 0; i < 500 && line_q.size() < 4; i++) begin
      @(negedge clk); #1;
    end
    sched_en = 1'b0;
    wait_fd(1, ok);
    checks++; if (!ok || line_q.size() !== 11) begin failures++; $display("FAIL en_finish: got %0d bytes expected 11", line_q.size()); end
    extra = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (sched_busy || req_ready != 3'b000) extra++;
    end
    checks++; if (extra !== 0 || rdy_q.size() !== 1 || line_q.size() !== 11) begin failures++; $display("FAIL en_hold: got %0d active cycles %0d bytes expected 0 and 11", extra, line_q.size()); end
    sched_en = 1'b1;
    @(negedge clk); #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL en_regrant: got %b expected 100", req_ready); end
    req_valid = '0;
    wait_fd(2, ok);
    checks++; if (line_q.size() !== 22 || line_q[12] !== 8'h68) begin failures++; $display("FAIL en_second: got %0d bytes hdr %h expected 22 bytes hdr 68", line_q.size(), line_q[12]); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp [11];
    bit ok;
    int hit;
    exp = '{8'hA5, 8'h48, 8'h0D, 8'hF0, 8'hAD, 8'h0B, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h31};
    do_reset();
    sched_en = 1'b1;
    send_word(2'd0, 64'hDEAD_BEEF_0BAD_F00D, ok);
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (line_q.size() == 7 && byte_start) begin
        hit = 1;
        break;
      end
    end
    checks++; if (hit !== 1) begin failures++; $display("FAIL midrst_reach: got no payload byte 5 expected one"); end
    rst_n = 1'b0;
    #1;
    checks++; if (byte_start !== 1'b0 || sched_busy !== 1'b0 || req_ready !== 3'b000) begin failures++; $display("FAIL midrst_outputs: got start=%b busy=%b ready=%b expected 0 0 000", byte_start, sched_busy, req_ready); end
    checks++; if (byte_data !== 8'h00 || frame_count !== 16'h0000) begin failures++; $display("FAIL midrst_regs: got data=%h count=%h expected 00 0000", byte_data, frame_count); end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    #1;
    checks++; if (line_q.size() !== 0 || sched_busy !== 1'b0) begin failures++; $display("FAIL midrst_no_resume: got %0d bytes busy=%b expected 0 0", line_q.size(), sched_busy); end
    send_word(2'd0, 64'hDEAD_BEEF_0BAD_F00D, ok);
    wait_fd(1, ok);
    checks++; if (line_q.size() !== 11) begin failures++; $display("FAIL midrst_len: got %0d expected 11", line_q.size()); end
    for (int i = 0; i < 11 && i < line_q.size(); i++) begin
      checks++; if (line_q[i] !== exp[i]) begin failures++; $display("FAIL midrst_byte%0d: got %h expected %h", i, line_q[i], exp[i]); end
    end
  endtask

  task automatic test_count_wrap;
    bit ok;
    do_reset();
    sched_en = 1'b1;
    @(negedge clk);
    force dut.frame_count = 16'hFFFE;
    @(negedge clk);
    release dut.frame_count;
    #1;
    checks++; if (frame_count !== 16'hFFFE) begin failures++; $display("FAIL wrap_preload: got %h expected fffe", frame_count); end
    send_word(2'd1, 64'h0, ok);
    wait_fd(1, ok);
    checks++; if (frame_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_first: got %h expected ffff", frame_count); end
    send_word(2'd2, 64'h0, ok);
    wait_fd(2, ok);
    checks++; if (frame_count !== 16'h0000) begin failures++; $display("FAIL wrap_second: got %h expected 0000", frame_count); end
  endtask

  task automatic test_zero_word;
    logic [7:0] exp [11];
    bit ok;
    exp = '{8'hA5, 8'h68, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h68};
    do_reset();
    sched_en = 1'b1;
    send_word(2'd2, 64'h0, ok);
    wait_fd(1, ok);
    checks++; if (rdy_q.size() !== 1 || rdy_q[0] !== 3'b100) begin failures++; $display("FAIL zero_ready: got %0d pulses first %b expected 1 pulse 100", rdy_q.size(), rdy_q[0]); end
    checks++; if (line_q.size() !== 11) begin failures++; $display("FAIL zero_len: got %0d expected 11", line_q.size()); end
    for (int i = 0; i < 11 && i < line_q.size(); i++) begin
      checks++; if (line_q[i] !== exp[i]) begin failures++; $display("FAIL zero_byte%0d: got %h expected %h", i, line_q[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_sched_en();
    test_reset_mid_frame();
    test_count_wrap();
    test_zero_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
